psg_stereo_mixer: RTL and testbench

//  Downstream stage of the YM2149 PSG core. Consumes the linearised per-channel DAC words A/B/C and the

---
 rtl/psg_stereo_mixer_if.sv | 10 +
 rtl/psg_stereo_mixer.sv | 173 +++++++++++++++++
 tb/tb_psg_stereo_mixer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psg_stereo_mixer_if.sv
// rtl/psg_stereo_mixer_if.sv - stereo PCM output stream between the mixer and the audio serialiser
interface psg_stereo_mixer_if;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_l, output out_r, output out_valid, input out_ready);
    modport slave  (input out_l, input out_r, input out_valid, output out_ready);
endinterface

// File: rtl/psg_stereo_mixer.sv
// rtl/psg_stereo_mixer.sv - PSG A/B/C pan mixer on one shared multiplier, signed 16-bit stereo out
// Optional DC blocker stage enabled by defining PSG_DCFILT_EN.
module psg_stereo_mixer #(
    parameter int DAC_BITS = 8,
    parameter int DC_SHIFT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en_i,
    input  logic                sample_i,
    input  logic [DAC_BITS-1:0] a_i,
    input  logic [DAC_BITS-1:0] b_i,
    input  logic [DAC_BITS-1:0] c_i,
    input  logic [7:0]          gain_al_i,
    input  logic [7:0]          gain_ar_i,
    input  logic [7:0]          gain_bl_i,
    input  logic [7:0]          gain_br_i,
    input  logic [7:0]          gain_cl_i,
    input  logic [7:0]          gain_cr_i,
    output logic                overrun_o,
    psg_stereo_mixer_if.master  out_if
);
    localparam int PROD_W = DAC_BITS + 8;
    localparam int ACC_W  = DAC_BITS + 10;

    if (DAC_BITS < 8 || DAC_BITS > 14 || DC_SHIFT < 4 || DC_SHIFT > 12) begin : g_bad_cfg
        $error("psg_stereo_mixer: parameter out of range");
    end

`ifdef PSG_DCFILT_EN
    typedef enum logic [2:0] {S_IDLE, S_MAC, S_FMT, S_DCF, S_OUT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_MAC, S_FMT, S_OUT} state_t;
`endif

    state_t              state_q;
    logic [2:0]          step_q;
    logic [DAC_BITS-1:0] a_q, b_q, c_q;
    // Gain slots are stored in MAC order: al, bl, cl, ar, br, cr.
    logic [7:0]          gain_q [6];
    logic [ACC_W-1:0]    acc_l_q, acc_r_q;
    logic [15:0]         out_l_q, out_r_q;
    logic                out_valid_q;
    logic                overrun_q;

    logic                strobe;
    logic [DAC_BITS-1:0] dac_sel;
    logic [PROD_W-1:0]   prod_d;
    logic [15:0]         pcm_l_d, pcm_r_d;

    assign strobe = sample_i & clk_en_i;

    always_comb begin
        dac_sel = c_q;
        case (step_q)
            3'd0, 3'd3: dac_sel = a_q;
            3'd1, 3'd4: dac_sel = b_q;
            default:    dac_sel = c_q;
        endcase
        prod_d  = {8'b0, dac_sel} * {{DAC_BITS{1'b0}}, gain_q[step_q]};
        pcm_l_d = acc_l_q[ACC_W-1 -: 16] ^ 16'h8000;
        pcm_r_d = acc_r_q[ACC_W-1 -: 16] ^ 16'h8000;
    end

`ifdef PSG_DCFILT_EN
    logic [15:0]        fmt_l_q, fmt_r_q;
    logic signed [17:0] xp_l_q, yp_l_q, xp_r_q, yp_r_q;
    logic signed [17:0] x_l, x_r, y_l, y_r;
    logic [15:0]        sat_l, sat_r;

    function automatic logic [15:0] sat16(input logic signed [17:0] y);
        if (y > 18'sd32767)
            return 16'h7FFF;
        else if (y < -18'sd32768)
            return 16'h8000;
        else
            return y[15:0];
    endfunction

    always_comb begin
        x_l   = $signed({{2{fmt_l_q[15]}}, fmt_l_q});
        x_r   = $signed({{2{fmt_r_q[15]}}, fmt_r_q});
        y_l   = x_l - xp_l_q + yp_l_q - (yp_l_q >>> DC_SHIFT);
        y_r   = x_r - xp_r_q + yp_r_q - (yp_r_q >>> DC_SHIFT);
        sat_l = sat16(y_l);
        sat_r = sat16(y_r);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            for (int i = 0; i < 6; i++) gain_q[i] <= 8'd0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            out_l_q     <= 16'd0;
            out_r_q     <= 16'd0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef PSG_DCFILT_EN
            fmt_l_q     <= 16'd0;
            fmt_r_q     <= 16'd0;
            xp_l_q      <= '0;
            yp_l_q      <= '0;
            xp_r_q      <= '0;
            yp_r_q      <= '0;
`endif
        end else begin
            overrun_q <= strobe && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: if (strobe) begin
                    a_q       <= a_i;
                    b_q       <= b_i;
                    c_q       <= c_i;
                    gain_q[0] <= gain_al_i;
                    gain_q[1] <= gain_bl_i;
                    gain_q[2] <= gain_cl_i;
                    gain_q[3] <= gain_ar_i;
                    gain_q[4] <= gain_br_i;
                    gain_q[5] <= gain_cr_i;
                    acc_l_q   <= '0;
                    acc_r_q   <= '0;
                    step_q    <= 3'd0;
                    state_q   <= S_MAC;
                end
                S_MAC: begin
                    if (step_q < 3'd3) acc_l_q <= acc_l_q + {2'b0, prod_d};
                    else               acc_r_q <= acc_r_q + {2'b0, prod_d};
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd5) state_q <= S_FMT;
                end
`ifdef PSG_DCFILT_EN
                S_FMT: begin
                    fmt_l_q <= pcm_l_d;
                    fmt_r_q <= pcm_r_d;
                    state_q <= S_DCF;
                end
                S_DCF: begin
                    out_l_q     <= sat_l;
                    out_r_q     <= sat_r;
                    xp_l_q      <= x_l;
                    xp_r_q      <= x_r;
                    yp_l_q      <= $signed({{2{sat_l[15]}}, sat_l});
                    yp_r_q      <= $signed({{2{sat_r[15]}}, sat_r});
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
`else
                S_FMT: begin
                    out_l_q     <= pcm_l_d;
                    out_r_q     <= pcm_r_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
`endif
                S_OUT: if (out_if.out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_if.out_l     = out_l_q;
    assign out_if.out_r     = out_r_q;
    assign out_if.out_valid = out_valid_q;
    assign overrun_o        = overrun_q;
endmodule

// File: tb/tb_psg_stereo_mixer.sv
// tb/tb_psg_stereo_mixer.sv - scoreboard bench for psg_stereo_mixer with an arithmetic reference model
module tb_psg_stereo_mixer;
    localparam int DAC_BITS = 8;
    localparam int DC_SHIFT = 8;
`ifdef PSG_DCFILT_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 7;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en, sample;
    logic [7:0] a, b, c, gal, gar, gbl, gbr, gcl, gcr;
    logic       overrun;

    psg_stereo_mixer_if bus ();

    psg_stereo_mixer #(.DAC_BITS(DAC_BITS), .DC_SHIFT(DC_SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en_i  (clk_en),
        .sample_i  (sample),
        .a_i       (a),
        .b_i       (b),
        .c_i       (c),
        .gain_al_i (gal),
        .gain_ar_i (gar),
        .gain_bl_i (gbl),
        .gain_br_i (gbr),
        .gain_cl_i (gcl),
        .gain_cr_i (gcr),
        .overrun_o (overrun),
        .out_if    (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q [$];
    int          xp_l, yp_l, xp_r, yp_r;
    int          ov_exp = 0;
    int          ov_seen = 0;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        xp_l = 0; yp_l = 0; xp_r = 0; yp_r = 0;
        exp_q.delete();
    endtask

    // Offset-binary top 16 bits of the accumulated sum, flipped to two's complement.
    function automatic int pcm_of(input int acc);
        return ((acc >> (DAC_BITS - 6)) & 32'hFFFF) ^ 32'h8000;
    endfunction

    task automatic model_dc(input int pcm, inout int xp, inout int yp, output int res);
        int x, y;
        x = (pcm >= 32768) ? pcm - 65536 : pcm;
        y = x - xp + yp - (yp >>> DC_SHIFT);
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        xp = x;
        yp = y;
        res = y & 32'hFFFF;
    endtask

    task automatic push_expected(input bit use_const, input int cl, input int cr);
        int accl, accr, pl, pr;
        accl = int'(a) * int'(gal) + int'(b) * int'(gbl) + int'(c) * int'(gcl);
        accr = int'(a) * int'(gar) + int'(b) * int'(gbr) + int'(c) * int'(gcr);
        pl = pcm_of(accl);
        pr = pcm_of(accr);
`ifdef PSG_DCFILT_EN
        model_dc(pl, xp_l, yp_l, pl);
        model_dc(pr, xp_r, yp_r, pr);
`endif
        if (use_const) exp_q.push_back({cl[15:0], cr[15:0]});
        else           exp_q.push_back({pl[15:0], pr[15:0]});
    endtask

    task automatic set_inputs(input int va, input int vb, input int vc, input int al, input int ar,
                              input int bl, input int br, input int cl, input int cr);
        a = va[7:0]; b = vb[7:0]; c = vc[7:0];
        gal = al[7:0]; gar = ar[7:0]; gbl = bl[7:0]; gbr = br[7:0]; gcl = cl[7:0]; gcr = cr[7:0];
    endtask

    task automatic rand_inputs();
        set_inputs($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    task automatic issue_strobe(input bit use_const, input int cl, input int cr);
        sample = 1'b1;
        clk_en = 1'b1;
        push_expected(use_const, cl, cr);
        tick();
        sample = 1'b0;
        clk_en = 1'b0;
    endtask

    task automatic busy_strobe();
        sample = 1'b1;
        clk_en = 1'b1;
        tick();
        sample = 1'b0;
        clk_en = 1'b0;
        ov_exp++;
    endtask

    task automatic wait_valid(input int exp_n, input string name);
        int n = 0;
        while (!bus.out_valid && n < 60) begin
            tick();
            n++;
        end
        check(name, n, exp_n);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    // Monitor: pops the scoreboard on each handshake and checks the held sample under backpressure.
    logic        pv = 1'b0, prdy = 1'b0;
    logic [31:0] pdata = '0;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (overrun) ov_seen++;
            if (pv && !prdy) begin
                check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                check("hold_data", {bus.out_l, bus.out_r}, pdata);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got %h expected none at %0t", {bus.out_l, bus.out_r}, $time);
                end else begin
                    check("sample", {bus.out_l, bus.out_r}, exp_q.pop_front());
                end
            end
            pv    = bus.out_valid;
            prdy  = bus.out_ready;
            pdata = {bus.out_l, bus.out_r};
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any;
        rst = 1'b1; clk_en = 1'b0; sample = 1'b0; bus.out_ready = 1'b1;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) tick();
        check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_l", {16'b0, bus.out_l}, 32'd0);
        check("rst_out_r", {16'b0, bus.out_r}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);
        rst = 1'b0;
        tick();

        // Single tone on the left only.
        set_inputs(255, 0, 0, 255, 0, 0, 0, 0, 0);
        issue_strobe(1'b1, 32'hBF80, 32'h8000);
        wait_valid(LAT, "latency_tone");
        wait_drain();

        // Full scale twice back to back, then silence.
        do_reset();
        set_inputs(255, 255, 255, 255, 255, 255, 255, 255, 255);
        issue_strobe(1'b1, 32'h3E80, 32'h3E80);
        wait_drain();
`ifdef PSG_DCFILT_EN
        issue_strobe(1'b1, 32'h3E42, 32'h3E42);
`else
        issue_strobe(1'b1, 32'h3E80, 32'h3E80);
`endif
        wait_drain();
        set_inputs(0, 0, 0, 255, 255, 255, 255, 255, 255);
`ifdef PSG_DCFILT_EN
        issue_strobe(1'b0, 0, 0);
`else
        issue_strobe(1'b1, 32'h8000, 32'h8000);
`endif
        wait_drain();

        // Strobe without clk_en must not start a sample.
        rand_inputs();
        sample = 1'b1;
        clk_en = 1'b0;
        any = 1'b0;
        repeat (12) begin
            tick();
            any |= bus.out_valid;
        end
        sample = 1'b0;
        check("gated_no_output", {31'b0, any}, 32'd0);

        // Inputs changed mid-flight must not affect the latched sample.
        rand_inputs();
        issue_strobe(1'b0, 0, 0);
        tick();
        rand_inputs();
        wait_valid(LAT - 1, "latency_latched");
        wait_drain();

        // Backpressure with a dropped second strobe.
        bus.out_ready = 1'b0;
        rand_inputs();
        issue_strobe(1'b0, 0, 0);
        repeat (9) tick();
        rand_inputs();
        busy_strobe();
        check("overrun_pulse", {31'b0, overrun}, 32'd1);
        tick();
        check("overrun_end", {31'b0, overrun}, 32'd0);
        repeat (9) tick();
        check("stalled_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        wait_drain();
        check("idle_after_xfer", {31'b0, bus.out_valid}, 32'd0);
        any = 1'b0;
        repeat (10) begin
            tick();
            any |= bus.out_valid;
        end
        check("single_transfer", {31'b0, any}, 32'd0);

        // Reset in the middle of MAC abandons the sample.
        do_reset();
        set_inputs(255, 0, 0, 255, 0, 0, 0, 0, 0);
        issue_strobe(1'b1, 32'hBF80, 32'h8000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_out_l", {16'b0, bus.out_l}, 32'd0);
        check("midrst_out_r", {16'b0, bus.out_r}, 32'd0);
        rst = 1'b0;
        model_reset();
        any = 1'b0;
        repeat (12) begin
            tick();
            any |= bus.out_valid;
        end
        check("midrst_no_output", {31'b0, any}, 32'd0);
        issue_strobe(1'b1, 32'hBF80, 32'h8000);
        wait_valid(LAT, "latency_after_rst");
        wait_drain();

        // Randomised samples with random consumer stalls and occasional busy strobes.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_inputs();
            issue_strobe(1'b0, 0, 0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 4)) tick();
                busy_strobe();
            end
            wait_drain();
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) tick();
        check("overrun_count", ov_seen, ov_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
